// File: rtl/hif_i2c_master_seq.sv
// I2C master with a quarter-period SCL divider, N-byte read/write bursts, ACK/NACK
// reporting, clock stretching and arbitration-loss detection on open-drain pads.
module hif_i2c_master_seq #(
    parameter int CLK_DIV   = 25,
    parameter int MAX_BYTES = 4,
    parameter int LEN_W     = 3
) (
    input  logic                   xtal_clk,
    input  logic                   por_rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [6:0]             cmd_dev_addr,
    input  logic                   cmd_rnw,
    input  logic [LEN_W-1:0]       cmd_len,
    input  logic [8*MAX_BYTES-1:0] cmd_wdata,
    output logic [8*MAX_BYTES-1:0] rd_data,
    output logic                   busy,
    output logic                   done,
    output logic                   nack,
    output logic                   arb_lost,
    input  logic                   scl_i,
    input  logic                   sda_i,
    output logic                   scl_oe,
    output logic                   sda_oe
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_BYTES);

    typedef enum logic [3:0] {IDLE, START, ADDR, AACK, WBYTE, WACK, RBYTE, MACK, STOP} state_t;

    state_t                   state, state_n;
    logic [DIV_W-1:0]         div_cnt;
    logic [1:0]               qtr;
    logic [2:0]               bit_cnt;
    logic [LEN_W-1:0]         byte_idx;
    logic [6:0]               addr_q;
    logic                     rnw_q;
    logic [LEN_W-1:0]         len_q;
    logic [8*MAX_BYTES-1:0]   wdata_q;
    logic [7:0]               rx_sh;
    logic                     rx_bit;
    logic [7:0]               wr_byte;
    logic [7:0]               tx_byte;
    logic                     tx_bit;
    logic                     hold, tick, sample, q_end, last_byte, accept, arb, finish;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = (state == IDLE) && cmd_valid;
    assign last_byte = (byte_idx == len_q - LEN_W'(1));

    // The divider freezes while SCL is released but still held low by a target.
    assign hold   = busy && !scl_oe && !scl_i;
    assign tick   = (div_cnt == DIV_LAST) && !hold;
    assign sample = tick && (qtr == 2'd2);
    assign q_end  = tick && (qtr == 2'd3);

    always_comb begin
        wr_byte = '0;
        for (int k = 0; k < MAX_BYTES; k++)
            if (byte_idx == LEN_W'(k)) wr_byte = wdata_q[8*k +: 8];
    end

    assign tx_byte = (state == ADDR) ? {addr_q, rnw_q} : wr_byte;
    assign tx_bit  = tx_byte[3'd7 - bit_cnt];

    // Line drive decode: data bits hold SCL low in q0/q3 and release it in q1/q2.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state)
            START:        begin sda_oe = (qtr != 2'd0); scl_oe = (qtr == 2'd3); end
            ADDR, WBYTE:  begin scl_oe = (qtr == 2'd0) || (qtr == 2'd3); sda_oe = ~tx_bit; end
            AACK, WACK,
            RBYTE:        scl_oe = (qtr == 2'd0) || (qtr == 2'd3);
            MACK:         begin scl_oe = (qtr == 2'd0) || (qtr == 2'd3); sda_oe = ~last_byte; end
            STOP:         begin scl_oe = (qtr == 2'd0); sda_oe = (qtr != 2'd3); end
            default:      ;
        endcase
    end

    always_comb begin
        state_n = state;
        arb     = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE:  if (cmd_valid) state_n = START;
            START: if (q_end) state_n = ADDR;
            ADDR, WBYTE: begin
                if (sample && tx_bit && !sda_i) begin
                    state_n = IDLE;
                    arb     = 1'b1;
                end else if (q_end && bit_cnt == 3'd7) begin
                    state_n = (state == ADDR) ? AACK : WACK;
                end
            end
            AACK: if (q_end) begin
                if (rx_bit || len_q == '0) state_n = STOP;
                else if (rnw_q)            state_n = RBYTE;
                else                       state_n = WBYTE;
            end
            WACK:  if (q_end) state_n = (rx_bit || last_byte) ? STOP : WBYTE;
            RBYTE: if (q_end && bit_cnt == 3'd7) state_n = MACK;
            MACK:  if (q_end) state_n = last_byte ? STOP : RBYTE;
            STOP: if (q_end) begin
                state_n = IDLE;
                finish  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge xtal_clk or negedge por_rst_n) begin
        if (!por_rst_n) state <= IDLE;
        else            state <= state_n;
    end

    always_ff @(posedge xtal_clk or negedge por_rst_n) begin
        if (!por_rst_n) begin
            div_cnt  <= '0;
            qtr      <= 2'd0;
            bit_cnt  <= 3'd0;
            byte_idx <= '0;
            done     <= 1'b0;
            nack     <= 1'b0;
            arb_lost <= 1'b0;
            rd_data  <= '0;
        end else begin
            done <= finish || arb;
            if (accept) begin
                nack     <= 1'b0;
                arb_lost <= 1'b0;
                rd_data  <= '0;
            end
            if (arb) arb_lost <= 1'b1;
            if (sample && (state == AACK || state == WACK) && sda_i) nack <= 1'b1;
            if (state == IDLE) begin
                div_cnt  <= '0;
                qtr      <= 2'd0;
                bit_cnt  <= 3'd0;
                byte_idx <= '0;
            end else begin
                if (tick) begin
                    div_cnt <= '0;
                    qtr     <= qtr + 2'd1;
                end else if (!hold) begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
                if (q_end) begin
                    if (state inside {ADDR, WBYTE, RBYTE}) bit_cnt <= bit_cnt + 3'd1;
                    if (state == WACK || state == MACK) byte_idx <= byte_idx + LEN_W'(1);
                    if (state == RBYTE && bit_cnt == 3'd7)
                        for (int k = 0; k < MAX_BYTES; k++)
                            if (byte_idx == LEN_W'(k)) rd_data[8*k +: 8] <= rx_sh;
                end
            end
        end
    end

    always_ff @(posedge xtal_clk) begin
        if (accept) begin
            addr_q  <= cmd_dev_addr;
            rnw_q   <= cmd_rnw;
            len_q   <= (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
            wdata_q <= cmd_wdata;
        end
        if (sample) rx_bit <= sda_i;
        if (sample && state == RBYTE) rx_sh <= {rx_sh[6:0], sda_i};
    end
endmodule
